// File: rtl/alu_mc_if.sv
// Handshake bundle for the multi-cycle ALU: request side (operands, op)
// and response side (result, flags), each with its own valid/ready pair.
interface alu_mc_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [3:0]            op;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  carry;
    logic                  overflow;
    logic                  negative;
    logic                  div_by_zero;

    // Issuer / consumer side
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, negative, div_by_zero
    );

    // ALU side
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, negative, div_by_zero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU. Single-cycle ops are evaluated from the bus at
// the accept edge and registered straight into DONE; MUL/MULHU/DIVU/REMU
// iterate one bit per cycle on a 2*DATA_WIDTH accumulator in BUSY.
module alu_mc #(
    parameter int DATA_WIDTH = 32,
    parameter bit MUL_DIV_EN = 1'b1
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_mc_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [W-1:0]    result_r;
    logic            zero_r;
    logic            carry_r;
    logic            overflow_r;
    logic            negative_r;
    logic            dbz_r;
    logic [3:0]      op_r;
    logic [W-1:0]    b_r;
    logic [2*W-1:0]  acc_r;
    logic [SW-1:0]   cnt_r;

    // Single-cycle datapath, evaluated from the bus operands
    logic [W:0]          add_s;
    logic [W:0]          sub_s;
    logic [SW-1:0]       shamt_s;
    logic signed [W-1:0] sra_s;
    logic [W-1:0]        sc_result_s;
    logic                sc_carry_s;
    logic                sc_overflow_s;
    logic                sc_known_s;
    logic                sc_dbz_s;
    logic                sc_zero_s;
    logic                is_md_s;
    logic                go_busy_s;

    // Iterative datapath
    logic [2*W-1:0]      step_next_s;
    logic [W-1:0]        fin_result_s;
    logic                last_step_s;

    assign add_s   = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_s   = {1'b0, bus.a} - {1'b0, bus.b};
    assign shamt_s = bus.b[SW-1:0];
    assign sra_s   = $signed(bus.a) >>> shamt_s;

    // Decode the presented op into a result and its flags
    always_comb begin
        sc_result_s   = '0;
        sc_carry_s    = 1'b0;
        sc_overflow_s = 1'b0;
        sc_known_s    = 1'b0;
        sc_dbz_s      = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sc_result_s   = add_s[W-1:0];
                sc_carry_s    = add_s[W];
                sc_overflow_s = (bus.a[W-1] == bus.b[W-1]) && (add_s[W-1] != bus.a[W-1]);
                sc_known_s    = 1'b1;
            end
            OP_SUB: begin
                sc_result_s   = sub_s[W-1:0];
                sc_carry_s    = ~sub_s[W];
                sc_overflow_s = (bus.a[W-1] != bus.b[W-1]) && (sub_s[W-1] != bus.a[W-1]);
                sc_known_s    = 1'b1;
            end
            OP_AND: begin
                sc_result_s = bus.a & bus.b;
                sc_known_s  = 1'b1;
            end
            OP_OR: begin
                sc_result_s = bus.a | bus.b;
                sc_known_s  = 1'b1;
            end
            OP_XOR: begin
                sc_result_s = bus.a ^ bus.b;
                sc_known_s  = 1'b1;
            end
            OP_SLL: begin
                sc_result_s = bus.a << shamt_s;
                sc_known_s  = 1'b1;
            end
            OP_SRL: begin
                sc_result_s = bus.a >> shamt_s;
                sc_known_s  = 1'b1;
            end
            OP_SRA: begin
                sc_result_s = sra_s;
                sc_known_s  = 1'b1;
            end
            OP_SLT: begin
                sc_result_s[0] = ($signed(bus.a) < $signed(bus.b));
                sc_known_s     = 1'b1;
            end
            OP_SLTU: begin
                sc_result_s[0] = (bus.a < bus.b);
                sc_known_s     = 1'b1;
            end
            OP_DIVU: begin
                // Only the divide-by-zero shortcut finishes here
                if (MUL_DIV_EN && (bus.b == '0)) begin
                    sc_result_s = '1;
                    sc_known_s  = 1'b1;
                    sc_dbz_s    = 1'b1;
                end else begin
                    sc_known_s  = 1'b0;
                end
            end
            OP_REMU: begin
                if (MUL_DIV_EN && (bus.b == '0)) begin
                    sc_result_s = bus.a;
                    sc_known_s  = 1'b1;
                    sc_dbz_s    = 1'b1;
                end else begin
                    sc_known_s  = 1'b0;
                end
            end
            default: begin
                // Reserved (and disabled mul/div): zero result, all flags clear
                sc_known_s = 1'b0;
            end
        endcase
    end

    assign sc_zero_s = sc_known_s && (sc_result_s == '0);
    assign is_md_s   = MUL_DIV_EN && (bus.op >= OP_MUL) && (bus.op <= OP_REMU);
    assign go_busy_s = is_md_s && !sc_dbz_s;

    generate
        if (MUL_DIV_EN) begin : g_md
            logic [W:0]   mul_sum_s;
            logic [W:0]   div_top_s;
            logic [W:0]   div_trial_s;
            logic [2*W-1:0] mul_next_s;
            logic [2*W-1:0] div_next_s;
            logic         is_div_s;

            // Shift-add: multiplier sits in the low half and is consumed LSB first
            assign mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, b_r} : {(W+1){1'b0}});
            assign mul_next_s = {mul_sum_s, acc_r[W-1:1]};

            // Restoring division: partial remainder high, quotient shifts in low.
            // The shifted remainder needs W+1 bits before the trial subtract.
            assign div_top_s   = {acc_r[2*W-1:W], acc_r[W-1]};
            assign div_trial_s = div_top_s - {1'b0, b_r};
            assign div_next_s  = div_trial_s[W]
                               ? {div_top_s[W-1:0],   acc_r[W-2:0], 1'b0}
                               : {div_trial_s[W-1:0], acc_r[W-2:0], 1'b1};

            assign is_div_s    = (op_r == OP_DIVU) || (op_r == OP_REMU);
            assign step_next_s = is_div_s ? div_next_s : mul_next_s;
        end else begin : g_no_md
            assign step_next_s = '0;
        end
    endgenerate

    // MUL and DIVU take the low half; MULHU and REMU take the high half
    assign fin_result_s = ((op_r == OP_MUL) || (op_r == OP_DIVU))
                        ? step_next_s[W-1:0] : step_next_s[2*W-1:W];
    assign last_step_s  = (cnt_r == SW'(W - 1));

    // Control FSM: accept in IDLE, iterate in BUSY, hold the result in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            negative_r  <= 1'b0;
            dbz_r       <= 1'b0;
            op_r        <= 4'd0;
            b_r         <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        if (go_busy_s) begin
                            state_r <= ST_BUSY;
                            acc_r   <= {{W{1'b0}}, bus.a};
                            b_r     <= bus.b;
                            op_r    <= bus.op;
                            cnt_r   <= '0;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= sc_result_s;
                            zero_r      <= sc_zero_s;
                            carry_r     <= sc_carry_s;
                            overflow_r  <= sc_overflow_s;
                            negative_r  <= sc_result_s[W-1];
                            dbz_r       <= sc_dbz_s;
                        end
                    end
                end
                ST_BUSY: begin
                    acc_r <= step_next_s;
                    cnt_r <= cnt_r + SW'(1);
                    if (last_step_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= fin_result_s;
                        zero_r      <= (fin_result_s == '0);
                        carry_r     <= 1'b0;
                        overflow_r  <= 1'b0;
                        negative_r  <= fin_result_s[W-1];
                        dbz_r       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.result      = result_r;
    assign bus.zero        = zero_r;
    assign bus.carry       = carry_r;
    assign bus.overflow    = overflow_r;
    assign bus.negative    = negative_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at DATA_WIDTH = 32.
module tb_alu_mc;
    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    int   fails;

    alu_mc_if #(.DATA_WIDTH(32)) bus ();

    alu_mc #(.DATA_WIDTH(32), .MUL_DIV_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {bus.zero, bus.carry, bus.overflow, bus.negative, bus.div_by_zero};
    endfunction

    // Issue one op with out_ready high; expects to start 1 ns after a posedge, in IDLE.
    // exp_flags = {zero, carry, overflow, negative, div_by_zero}
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [4:0] exp_flags, input int exp_lat);
        int   cycles;
        logic busy_ready;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom();
        bus.b        = $urandom();
        bus.op       = 4'($urandom_range(0, 15));
        cycles       = 0;
        busy_ready   = 1'b0;
        while (!bus.out_valid && cycles < 100) begin
            busy_ready = busy_ready | bus.in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end
        chk({tag, ".latency"}, 64'(cycles + 1), 64'(exp_lat));
        chk({tag, ".busy_in_ready"}, 64'(busy_ready), 64'd0);
        chk({tag, ".result"}, 64'(bus.result), 64'(exp_res));
        chk({tag, ".flags"}, 64'(flags()), 64'(exp_flags));
        @(posedge clk);
        #1;
        chk({tag, ".drained"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.op        = 4'd0;
        #12;
        chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset.result", 64'(bus.result), 64'd0);
        chk("reset.flags", 64'(flags()), 64'd0);
        chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b00110, 1);
        run_op("add_cry",  4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b11000, 1);
        run_op("sub_eq",   4'd1,  32'd5,         32'd5,         32'h0000_0000, 5'b11000, 1);
        run_op("sub_brw",  4'd1,  32'd3,         32'd5,         32'hFFFF_FFFE, 5'b00010, 1);
        run_op("sub_ovf",  4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b01100, 1);
        run_op("and",      4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'b00010, 1);
        run_op("or",       4'd3,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 5'b00000, 1);
        run_op("xor",      4'd4,  32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 5'b00000, 1);
        run_op("sll31",    4'd5,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 5'b00010, 1);
        run_op("srl",      4'd6,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 5'b00000, 1);
        run_op("sra",      4'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 5'b00010, 1);
        run_op("slt",      4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 5'b00000, 1);
        run_op("sltu_1",   4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 5'b00000, 1);
        run_op("sltu_0",   4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b10000, 1);
        run_op("rsv14",    4'd14, 32'd5,         32'd5,         32'h0000_0000, 5'b00000, 1);
        run_op("rsv15",    4'd15, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 5'b00000, 1);
        run_op("mul_ff",   4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5'b00000, 33);
        run_op("mulhu_ff", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'b00010, 33);
        run_op("mul_dec",  4'd10, 32'd12345,     32'd1000,      32'h00BC_5EA8, 5'b00000, 33);
        run_op("divu",     4'd12, 32'd100,       32'd7,         32'd14,        5'b00000, 33);
        run_op("remu",     4'd13, 32'd100,       32'd7,         32'd2,         5'b00000, 33);
        run_op("divu_sm",  4'd12, 32'd7,         32'd100,       32'd0,         5'b10000, 33);
        run_op("divu_max", 4'd12, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 5'b00010, 33);
        run_op("remu_max", 4'd13, 32'hFFFF_FFFF, 32'd2,         32'd1,         5'b00000, 33);
        run_op("divu_dbz", 4'd12, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 5'b00011, 1);
        run_op("remu_dbz", 4'd13, 32'h0000_1234, 32'd0,         32'h0000_1234, 5'b00001, 1);

        // Backpressure: result held while out_ready is low, new requests ignored
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 4'd0;
        bus.a         = 32'h7FFF_FFFF;
        bus.b         = 32'h0000_0001;
        @(posedge clk);
        #1;
        bus.a = 32'd1;
        bus.b = 32'd1;
        chk("bp.out_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.hold_valid", 64'({bus.out_valid, bus.in_ready}), 64'b10);
            chk("bp.hold_result", 64'(bus.result), 64'h8000_0000);
            chk("bp.hold_flags", 64'(flags()), 64'b00110);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.release", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp.next_valid", 64'(bus.out_valid), 64'd1);
        chk("bp.next_result", 64'(bus.result), 64'd2);
        @(posedge clk);
        #1;

        // Leave a nonzero result visible, then reset in the middle of a MUL
        run_op("pre_rst", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'b00010, 33);
        bus.in_valid = 1'b1;
        bus.op       = 4'd10;
        bus.a        = 32'd9;
        bus.b        = 32'd9;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst.busy_result", 64'(bus.result), 64'hFFFF_FFFE);
        rst_n = 1'b0;
        #1;
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.result", 64'(bus.result), 64'd0);
        chk("rst.flags", 64'(flags()), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.idle", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        run_op("post_rst", 4'd0, 32'd3, 32'd4, 32'd7, 5'b00000, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle combinational ALU in the execute stage.
- Full RV32I-style integer op set, registered in one cycle.
- Optional iterative multiply/divide, DATA_WIDTH iterations.
- Valid/ready handshake on both input and output sides, so the core can stall on long ops.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of two and at least 8.
- MUL_DIV_EN, 1, 1 = implement MUL/MULHU/DIVU/REMU; 0 = those opcodes behave as reserved.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  DATA_WIDTH  operand A.
- b  input  DATA_WIDTH  operand B.
- op  input  4  operation code (encoding below).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  DATA_WIDTH  registered result.
- zero  output  1  result == 0.
- carry  output  1  ADD carry-out; SUB no-borrow (a >= b unsigned); 0 otherwise.
- overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.
- negative  output  1  result[DATA_WIDTH-1].
- div_by_zero  output  1  DIVU/REMU issued with b == 0.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - 10 MUL (low half), 11 MULHU (high half, unsigned), 12 DIVU, 13 REMU.
  - 14-15 reserved: result 0, all flags 0, single-cycle.
- Shift amount = b[$clog2(DATA_WIDTH)-1:0]; upper bits of b are ignored.
- SLT/SLTU produce 0 or 1, zero-extended.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, latch operands and op. Single-cycle op -> DONE. MUL/MULHU/DIVU/REMU -> BUSY, except DIVU/REMU with b == 0 -> DONE.
  - BUSY: one shift-add (mul) or restoring-division step per cycle, 2*DATA_WIDTH-bit accumulator, iteration counter 0..DATA_WIDTH-1. After the final step -> DONE.
  - DONE: out_valid = 1. result and flags are held stable until out_ready; on out_valid & out_ready -> IDLE.
- No accept in DONE; back-to-back throughput is one op per 2 cycles minimum.
- Latency (accept edge k):
  - single-cycle ops and divide-by-zero: out_valid from edge k+1.
  - mul/div: out_valid from edge k+DATA_WIDTH+1.
- Divide by zero: DIVU = all ones, REMU = a, div_by_zero = 1. div_by_zero is 0 for every other case.
- Flags are computed from the final result and registered with it.
- MUL_DIV_EN = 0: opcodes 10-13 behave as reserved. No multiplier/divider logic is instantiated.
- Reset, including mid-BUSY or mid-DONE:
  - state -> IDLE immediately.
  - out_valid, result, all flags, counter and accumulator -> 0.
  - in_ready = 1 after deassertion; any in-flight op is discarded.
- Inputs a/b/op are sampled only on in_valid & in_ready; changes at other times have no effect.

Test Plan (DATA_WIDTH = 32):
- ADD a=0x7FFFFFFF, b=1 -> out_valid 1 cycle after accept; result 0x80000000, overflow 1, carry 0, negative 1, zero 0.
- SUB a=b=5 -> result 0, zero 1, carry 1.
- SLTU a=1, b=0xFFFFFFFF -> result 1.
- SRA a=0x80000000, b=0x24 -> result 0xF8000000 (shift amount 4).
- MUL a=b=0xFFFFFFFF -> result 1; MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE.
  - For both: out_valid exactly 33 cycles after accept, in_ready 0 throughout.
- DIVU 100/7 -> result 14; REMU 100/7 -> result 2.
- DIVU 0x1234/0 -> result 0xFFFFFFFF, div_by_zero 1, latency 1.
- REMU 0x1234/0 -> result 0x1234, div_by_zero 1.
- Backpressure: hold out_ready 0 for 5 cycles after an ADD -> result and flags stable, in_ready 0. Raise out_ready -> in_ready 1 on the next cycle, and a new op is accepted.
- Reset at BUSY cycle 10 of a MUL -> out_valid 0 and result 0 immediately. After release, ADD 3+4 -> result 7 with 1-cycle latency.
